// File: rtl/ddr_stream_burst_writer.sv
// Drains NUM_CH sample FIFOs as AXI4 INCR write bursts into per-channel LPDDR4 ring regions.
// Latency: AWVALID one cycle after a request is seen in IDLE; burst occupies BURST_LEN+3 cycles unstalled.
// Backpressure: AW/W/B handshakes stall the FSM in place; one burst outstanding; FIFO pops only on accepted W beats.
module ddr_stream_burst_writer #(
    parameter int                NUM_CH      = 4,
    parameter int                DATA_W      = 512,
    parameter int                ADDR_W      = 33,
    parameter int                ID_W        = 6,
    parameter int                BURST_LEN   = 16,
    parameter int                REGION_LOG2 = 24,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    input  logic                     enable,
    input  logic                     ptr_clr,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [NUM_CH-1:0]        ch_pop,
    output logic [ID_W-1:0]          AWID,
    output logic [ADDR_W-1:0]        AWADDR,
    output logic [7:0]               AWLEN,
    output logic [2:0]               AWSIZE,
    output logic [1:0]               AWBURST,
    output logic                     AWVALID,
    input  logic                     AWREADY,
    output logic [DATA_W-1:0]        WDATA,
    output logic [DATA_W/8-1:0]      WSTRB,
    output logic                     WLAST,
    output logic                     WVALID,
    input  logic                     WREADY,
    input  logic [ID_W-1:0]          BID,
    input  logic [1:0]               BRESP,
    input  logic                     BVALID,
    output logic                     BREADY,
    output logic                     busy,
    output logic [NUM_CH-1:0]        burst_done,
    output logic [NUM_CH-1:0]        ch_wrap,
    output logic [15:0]              bresp_err_cnt
);

    localparam int GW          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BCW         = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int BURST_BYTES = BURST_LEN * DATA_W / 8;
    localparam logic [REGION_LOG2-1:0] OFS_INC   = REGION_LOG2'(BURST_BYTES);
    localparam logic [BCW-1:0]         LAST_BEAT = BCW'(BURST_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

    state_t                                state_q, state_d;
    logic [GW-1:0]                         grant_q, grant_d;
    logic [GW-1:0]                         last_grant_q, last_grant_d;
    logic [BCW-1:0]                        beat_q, beat_d;
    logic [ADDR_W-1:0]                     awaddr_q, awaddr_d;
    logic [NUM_CH-1:0][REGION_LOG2-1:0]    offset_q, offset_d;
    logic [15:0]                           bresp_err_cnt_q, bresp_err_cnt_d;
    logic [NUM_CH-1:0]                     done_q, done_d;
    logic [NUM_CH-1:0]                     wrap_q, wrap_d;
    logic [REGION_LOG2-1:0]                ofs_nxt;
    logic                                  req_found;
    logic [GW-1:0]                         gnt_sel;
    int                                    idx;
    logic                                  unused_bid;

    assign unused_bid = ^BID;

    // Round-robin search starts one past the channel that completed last.
    always_comb begin
        req_found = 1'b0;
        gnt_sel   = '0;
        idx       = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = (int'(last_grant_q) + k) % NUM_CH;
            if (!req_found && ch_req[idx]) begin
                req_found = 1'b1;
                gnt_sel   = GW'(idx);
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        last_grant_d    = last_grant_q;
        beat_d          = beat_q;
        awaddr_d        = awaddr_q;
        offset_d        = offset_q;
        bresp_err_cnt_d = bresp_err_cnt_q;
        done_d          = '0;
        wrap_d          = '0;
        ofs_nxt         = offset_q[grant_q] + OFS_INC;
        case (state_q)
            S_IDLE: begin
                if (enable && req_found) begin
                    grant_d  = gnt_sel;
                    awaddr_d = BASE_ADDR + (ADDR_W'(gnt_sel) << REGION_LOG2)
                             + ADDR_W'(offset_q[gnt_sel]);
                    state_d  = S_AW;
                end else if (ptr_clr) begin
                    offset_d = '0;
                end
            end
            S_AW: begin
                if (AWREADY) begin
                    beat_d  = '0;
                    state_d = S_W;
                end
            end
            S_W: begin
                if (WREADY) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = S_B;
                    end else begin
                        beat_d = beat_q + BCW'(1);
                    end
                end
            end
            S_B: begin
                if (BVALID) begin
                    if (BRESP != 2'b00 && bresp_err_cnt_q != 16'hFFFF) begin
                        bresp_err_cnt_d = bresp_err_cnt_q + 16'd1;
                    end
                    done_d[grant_q]   = 1'b1;
                    offset_d[grant_q] = ofs_nxt;
                    if (ofs_nxt == '0) begin
                        wrap_d[grant_q] = 1'b1;
                    end
                    last_grant_d = grant_q;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q         <= S_IDLE;
            grant_q         <= '0;
            last_grant_q    <= GW'(NUM_CH - 1);
            beat_q          <= '0;
            awaddr_q        <= '0;
            offset_q        <= '0;
            bresp_err_cnt_q <= '0;
            done_q          <= '0;
            wrap_q          <= '0;
        end else begin
            state_q         <= state_d;
            grant_q         <= grant_d;
            last_grant_q    <= last_grant_d;
            beat_q          <= beat_d;
            awaddr_q        <= awaddr_d;
            offset_q        <= offset_d;
            bresp_err_cnt_q <= bresp_err_cnt_d;
            done_q          <= done_d;
            wrap_q          <= wrap_d;
        end
    end

    // Payload fields are forced to zero outside their phase so reset/idle values are clean.
    assign AWVALID       = (state_q == S_AW);
    assign AWADDR        = awaddr_q;
    assign AWID          = AWVALID ? ID_W'(grant_q) : '0;
    assign AWLEN         = AWVALID ? 8'(BURST_LEN - 1) : 8'd0;
    assign AWSIZE        = 3'($clog2(DATA_W / 8));
    assign AWBURST       = 2'b01;
    assign WVALID        = (state_q == S_W);
    assign WDATA         = WVALID ? ch_data[int'(grant_q) * DATA_W +: DATA_W] : '0;
    assign WSTRB         = '1;
    assign WLAST         = WVALID && (beat_q == LAST_BEAT);
    assign ch_pop        = (WVALID && WREADY) ? (NUM_CH'(1) << grant_q) : '0;
    assign BREADY        = (state_q == S_B);
    assign busy          = (state_q != S_IDLE);
    assign burst_done    = done_q;
    assign ch_wrap       = wrap_q;
    assign bresp_err_cnt = bresp_err_cnt_q;

endmodule

// File: tb/tb_ddr_stream_burst_writer.sv
// Directed bench: a default instance plus a 4 KB-region instance driven in lockstep from the same stimulus.
module tb_ddr_stream_burst_writer;

    logic          ACLK = 1'b0;
    logic          ARESETn = 1'b0;
    logic          enable = 1'b0;
    logic          ptr_clr = 1'b0;
    logic [3:0]    ch_req = 4'b0;
    logic [2047:0] ch_data = '0;
    logic          AWREADY = 1'b0;
    logic          WREADY = 1'b0;
    logic [5:0]    BID = 6'd0;
    logic [1:0]    BRESP = 2'b00;
    logic          BVALID = 1'b0;

    logic [3:0]   ch_pop, burst_done, ch_wrap;
    logic [5:0]   AWID;
    logic [32:0]  AWADDR;
    logic [7:0]   AWLEN;
    logic [2:0]   AWSIZE;
    logic [1:0]   AWBURST;
    logic         AWVALID, WLAST, WVALID, BREADY, busy;
    logic [511:0] WDATA;
    logic [63:0]  WSTRB;
    logic [15:0]  bresp_err_cnt;

    logic [3:0]   w_ch_pop, w_burst_done, w_ch_wrap;
    logic [5:0]   w_AWID;
    logic [32:0]  w_AWADDR;
    logic [7:0]   w_AWLEN;
    logic [2:0]   w_AWSIZE;
    logic [1:0]   w_AWBURST;
    logic         w_AWVALID, w_WLAST, w_WVALID, w_BREADY, w_busy;
    logic [511:0] w_WDATA;
    logic [63:0]  w_WSTRB;
    logic [15:0]  w_bresp_err_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int seq[4];

    ddr_stream_burst_writer dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .enable(enable), .ptr_clr(ptr_clr),
        .ch_req(ch_req), .ch_data(ch_data), .ch_pop(ch_pop),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .busy(busy), .burst_done(burst_done), .ch_wrap(ch_wrap), .bresp_err_cnt(bresp_err_cnt)
    );

    ddr_stream_burst_writer #(.REGION_LOG2(12)) dut_w (
        .ACLK(ACLK), .ARESETn(ARESETn), .enable(enable), .ptr_clr(ptr_clr),
        .ch_req(ch_req), .ch_data(ch_data), .ch_pop(w_ch_pop),
        .AWID(w_AWID), .AWADDR(w_AWADDR), .AWLEN(w_AWLEN), .AWSIZE(w_AWSIZE), .AWBURST(w_AWBURST),
        .AWVALID(w_AWVALID), .AWREADY(AWREADY),
        .WDATA(w_WDATA), .WSTRB(w_WSTRB), .WLAST(w_WLAST), .WVALID(w_WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(w_BREADY),
        .busy(w_busy), .burst_done(w_burst_done), .ch_wrap(w_ch_wrap), .bresp_err_cnt(w_bresp_err_cnt)
    );

    always #5 ACLK = ~ACLK;

    function automatic logic [511:0] word(input int ch, input int s);
        return 512'({8'(ch), 16'(s)});
    endfunction

    task automatic refresh_data();
        for (int i = 0; i < 4; i++) ch_data[i*512 +: 512] = word(i, seq[i]);
    endtask

    task automatic reset_dut();
        @(negedge ACLK);
        ARESETn = 1'b0; AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00; ptr_clr = 1'b0;
        repeat (2) @(negedge ACLK);
        ARESETn = 1'b1;
        for (int i = 0; i < 4; i++) seq[i] = 0;
        refresh_data();
    endtask

    // Plays the AXI slave for one burst of channel ch; optional random stalls on AW, W and B.
    task automatic do_burst(input int ch, input logic [32:0] exp_addr, input bit stall,
                            input logic [1:0] resp, output logic [32:0] addr2,
                            output logic [3:0] wrap1, output logic [3:0] wrap2);
        int n, beats, guard;
        bit seen;
        logic [3:0] oh;
        oh = 4'b0001 << ch;
        addr2 = '0; wrap1 = '0; wrap2 = '0; seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge ACLK); #1;
            seen = AWVALID;
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL aw_timeout ch%0d: AWVALID=0 after 20 cycles, required 1", ch);
            return;
        end
        n_tests++;
        if (AWADDR !== exp_addr || AWID !== 6'(ch) || AWLEN !== 8'd15 || AWSIZE !== 3'd6 || AWBURST !== 2'b01) begin
            n_fail++;
            $display("FAIL aw_payload ch%0d: addr=%h id=%0d len=%0d size=%0d burst=%0d, required addr=%h id=%0d len=15 size=6 burst=1",
                     ch, AWADDR, AWID, AWLEN, AWSIZE, AWBURST, exp_addr, ch);
        end
        addr2 = w_AWADDR;
        n = stall ? $urandom_range(1, 3) : 0;
        repeat (n) begin
            @(negedge ACLK); #1;
            n_tests++;
            if (AWVALID !== 1'b1 || AWADDR !== exp_addr) begin
                n_fail++;
                $display("FAIL aw_stable ch%0d: valid=%b addr=%h, required valid=1 addr=%h", ch, AWVALID, AWADDR, exp_addr);
            end
        end
        AWREADY = 1'b1;
        @(posedge ACLK);
        beats = 0; guard = 0;
        while (beats < 16 && guard < 200) begin
            @(negedge ACLK);
            AWREADY = 1'b0;
            WREADY = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            #1; guard++;
            n_tests++;
            if (WVALID !== 1'b1 || AWVALID !== 1'b0) begin
                n_fail++;
                $display("FAIL w_valid ch%0d beat %0d: WVALID=%b AWVALID=%b, required 1 0", ch, beats, WVALID, AWVALID);
            end
            n_tests++;
            if (WREADY) begin
                if (ch_pop !== oh || WLAST !== (beats == 15) || WDATA !== word(ch, seq[ch])) begin
                    n_fail++;
                    $display("FAIL w_beat ch%0d beat %0d: pop=%b last=%b data=%h, required pop=%b last=%b data=%h",
                             ch, beats, ch_pop, WLAST, WDATA[31:0], oh, (beats == 15), word(ch, seq[ch]) & 512'hFFFF_FFFF);
                end
            end else if (ch_pop !== 4'b0) begin
                n_fail++;
                $display("FAIL pop_stalled ch%0d beat %0d: pop=%b, required 0000", ch, beats, ch_pop);
            end
            @(posedge ACLK);
            if (WREADY) begin
                beats++;
                seq[ch]++;
            end
            #1 refresh_data();
        end
        n_tests++;
        if (beats != 16) begin
            n_fail++;
            $display("FAIL w_timeout ch%0d: %0d beats accepted, required 16", ch, beats);
            return;
        end
        @(negedge ACLK);
        WREADY = 1'b0;
        #1;
        n_tests++;
        if (BREADY !== 1'b1 || WVALID !== 1'b0) begin
            n_fail++;
            $display("FAIL b_phase ch%0d: BREADY=%b WVALID=%b, required 1 0", ch, BREADY, WVALID);
        end
        n = stall ? $urandom_range(1, 3) : 0;
        repeat (n) begin
            @(negedge ACLK); #1;
            n_tests++;
            if (BREADY !== 1'b1) begin
                n_fail++;
                $display("FAIL b_wait ch%0d: BREADY=%b, required 1", ch, BREADY);
            end
        end
        BVALID = 1'b1;
        BRESP = resp;
        @(posedge ACLK);
        @(negedge ACLK);
        BVALID = 1'b0;
        BRESP = 2'b00;
        #1;
        n_tests++;
        if (burst_done !== oh || busy !== 1'b0 || BREADY !== 1'b0) begin
            n_fail++;
            $display("FAIL b_done ch%0d: done=%b busy=%b bready=%b, required done=%b busy=0 bready=0",
                     ch, burst_done, busy, BREADY, oh);
        end
        wrap1 = ch_wrap;
        wrap2 = w_ch_wrap;
    endtask

    task automatic test_reset();
        ARESETn = 1'b0; enable = 1'b1; ch_req = 4'hF; AWREADY = 1'b1; WREADY = 1'b1;
        repeat (3) @(negedge ACLK);
        #1;
        n_tests++;
        if ({AWVALID, WVALID, WLAST, BREADY, busy} !== 5'b0 || ch_pop !== 4'b0
            || burst_done !== 4'b0 || ch_wrap !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: awv=%b wv=%b wl=%b br=%b busy=%b pop=%b done=%b wrap=%b, required all 0",
                     AWVALID, WVALID, WLAST, BREADY, busy, ch_pop, burst_done, ch_wrap);
        end
        n_tests++;
        if (AWADDR !== 33'd0 || AWLEN !== 8'd0 || AWID !== 6'd0 || WDATA !== 512'd0 || bresp_err_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_data: addr=%h len=%0d id=%0d data=%h cnt=%h, required all 0",
                     AWADDR, AWLEN, AWID, WDATA[31:0], bresp_err_cnt);
        end
        ch_req = 4'b0; AWREADY = 1'b0; WREADY = 1'b0;
        ARESETn = 1'b1;
        for (int i = 0; i < 4; i++) seq[i] = 0;
        refresh_data();
    endtask

    task automatic test_single();
        logic [32:0] a2;
        logic [3:0] w1, w2;
        ch_req = 4'b0001;
        do_burst(0, 33'd0, 1'b0, 2'b00, a2, w1, w2);
        do_burst(0, 33'd1024, 1'b0, 2'b00, a2, w1, w2);
        ch_req = 4'b0000;
        @(negedge ACLK);
        ptr_clr = 1'b1;
        @(negedge ACLK);
        ptr_clr = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ptr_clr_idle: busy=%b, required 0", busy);
        end
        ch_req = 4'b0001;
        do_burst(0, 33'd0, 1'b0, 2'b00, a2, w1, w2);
        ch_req = 4'b0000;
    endtask

    task automatic test_round_robin();
        logic [32:0] a2;
        logic [3:0] w1, w2;
        reset_dut();
        ch_req = 4'hF;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 4; i++)
                do_burst(i, (33'(i) << 24) + 33'(r * 1024), 1'b0, 2'b00, a2, w1, w2);
        ch_req = 4'h0;
    endtask

    task automatic test_wrap();
        logic [32:0] a2;
        logic [3:0] w1, w2;
        reset_dut();
        ch_req = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            do_burst(2, (33'd2 << 24) + 33'(k * 1024), 1'b0, 2'b00, a2, w1, w2);
            n_tests++;
            if (a2 !== 33'h2000 + 33'((k % 4) * 1024)) begin
                n_fail++;
                $display("FAIL wrap_addr burst %0d: addr=%h, required %h", k, a2, 33'h2000 + 33'((k % 4) * 1024));
            end
            n_tests++;
            if (w2 !== ((k == 3) ? 4'b0100 : 4'b0000) || w1 !== 4'b0000) begin
                n_fail++;
                $display("FAIL wrap_pulse burst %0d: small=%b big=%b, required small=%b big=0000",
                         k, w2, w1, (k == 3) ? 4'b0100 : 4'b0000);
            end
        end
        ch_req = 4'b0000;
    endtask

    task automatic test_stalls();
        logic [32:0] a2;
        logic [3:0] w1, w2;
        reset_dut();
        ch_req = 4'hF;
        for (int b = 0; b < 6; b++)
            do_burst(b % 4, (33'(b % 4) << 24) + 33'((b / 4) * 1024), 1'b1, 2'b00, a2, w1, w2);
        ch_req = 4'h0;
    endtask

    task automatic test_bresp_err();
        logic [32:0] a2;
        logic [3:0] w1, w2;
        logic [15:0] exp_cnt;
        reset_dut();
        ch_req = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            do_burst(0, 33'(k * 1024), 1'b0, (k < 3) ? 2'b10 : 2'b00, a2, w1, w2);
            exp_cnt = (k < 3) ? 16'(k + 1) : 16'd3;
            n_tests++;
            if (bresp_err_cnt !== exp_cnt) begin
                n_fail++;
                $display("FAIL err_cnt burst %0d: cnt=%h, required %h", k, bresp_err_cnt, exp_cnt);
            end
        end
        ch_req = 4'b0000;
        force dut.bresp_err_cnt_q = 16'hFFFE;
        repeat (2) @(posedge ACLK);
        release dut.bresp_err_cnt_q;
        @(negedge ACLK);
        ch_req = 4'b0001;
        for (int k = 4; k < 7; k++) begin
            do_burst(0, 33'(k * 1024), 1'b0, 2'b10, a2, w1, w2);
            n_tests++;
            if (bresp_err_cnt !== 16'hFFFF) begin
                n_fail++;
                $display("FAIL err_sat burst %0d: cnt=%h, required ffff", k, bresp_err_cnt);
            end
        end
        ch_req = 4'b0000;
    endtask

    task automatic test_reset_mid();
        logic [32:0] a2;
        logic [3:0] w1, w2;
        bit seen;
        reset_dut();
        ch_req = 4'b0001;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge ACLK); #1;
            seen = AWVALID;
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL rst_mid_aw: AWVALID=0, required 1");
        end
        AWREADY = 1'b1;
        @(posedge ACLK);
        for (int b = 0; b < 7; b++) begin
            @(negedge ACLK);
            AWREADY = 1'b0;
            WREADY = 1'b1;
            if (b == 6) ARESETn = 1'b0;
            @(posedge ACLK);
        end
        @(negedge ACLK);
        #1;
        n_tests++;
        if ({AWVALID, WVALID, WLAST, BREADY, busy} !== 5'b0 || ch_pop !== 4'b0 || WDATA !== 512'd0
            || AWADDR !== 33'd0 || AWLEN !== 8'd0 || AWID !== 6'd0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: awv=%b wv=%b wl=%b br=%b busy=%b pop=%b data=%h addr=%h, required all 0",
                     AWVALID, WVALID, WLAST, BREADY, busy, ch_pop, WDATA[31:0], AWADDR);
        end
        ARESETn = 1'b1;
        WREADY = 1'b0;
        for (int i = 0; i < 4; i++) seq[i] = 0;
        refresh_data();
        do_burst(0, 33'd0, 1'b0, 2'b00, a2, w1, w2);
    endtask

    task automatic test_enable_off();
        bit bad;
        enable = 1'b0;
        ch_req = 4'hF;
        bad = 1'b0;
        repeat (12) begin
            @(negedge ACLK); #1;
            if (AWVALID !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL enable_off: AWVALID or busy rose with enable=0, required both 0");
        end
        ch_req = 4'h0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_stalls();
        test_bresp_err();
        test_reset_mid();
        test_enable_off();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
